icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Miss/refill sequencer for the 4-way, 64-set, 512-bit-line ICache.
- Accepts a miss from ICache stage 2 and stalls the front end through IcacheStop.
- Issues one line-aligned burst read to the memory side and assembles 16 x 32-bit beats into a 512-bit line.
- Drives the stage-1 fill interface (InNewAble/InNewIndex/InNewTag/InNewDate) for exactly one cycle, then releases the pipeline.

Parameters:
LINE_BEATS, 16, beats per line; LINE_BEATS*BEAT_W must equal 512
BEAT_W, 32, memory read data width in bits
TIMEOUT_CYCLES, 255, max idle cycles between beats (used only with the optional feature)

Ports:
Clk  in  1  clock, all logic on posedge
Rest  in  1  reset, synchronous, active-high
MissReq  in  1  stage-2 miss pulse; sampled only in IDLE
MissPc  in  32  PC of the missing fetch
IcacheFlash  in  1  pipeline flush from ictrl
IcacheStop  out  1  stall to ICache stage 1/2 and PC
RdReq  out  1  burst read address valid
RdAddr  out  32  line address {MissPc[31:6],6'b0}
RdLen  out  8  LINE_BEATS-1
RdReady  in  1  address accepted when RdReq&RdReady
RdDataValid  in  1  read beat valid (no backpressure)
RdData  in  BEAT_W  read beat
InNewAble  out  1  stage-1 line write strobe
InNewIndex  out  6  MissPc[11:6]
InNewTag  out  20  MissPc[31:12]
InNewDate  out  512  assembled line
RefillDone  out  1  one-cycle pulse, coincident with InNewAble
RefillErr  out  1  one-cycle timeout pulse; tied 0 without the optional feature

Behaviour:
- Reset (Rest=1 at posedge): state IDLE; all outputs 0; line buffer, beat counter and Cancel cleared. Reset mid-burst abandons the burst and ignores later beats.
- States: IDLE, REQ, FILL, HOLD, WRITE.
- IDLE: on MissReq & ~IcacheFlash, latch MissPc, go to REQ. If MissReq & IcacheFlash in the same cycle, flush wins and the miss is dropped.
- REQ: RdReq=1 with RdAddr/RdLen stable until RdReady. Then go to FILL; beat counter is 0.
- FILL: each RdDataValid writes RdData to bits [k*BEAT_W +: BEAT_W] of the line buffer, k = counter, then counter+1.
  - On the beat where counter==LINE_BEATS-1: go to HOLD, or to IDLE if Cancel is set.
  - Beats arriving outside FILL are ignored.
- IcacheStop=1 in REQ and FILL, 0 in all other states.
- IcacheStop deassertion is registered; the stage-1 write enable is qualified by the previous cycle's stop.
- HOLD: one cycle with IcacheStop=0 and InNewAble=0, then WRITE.
- WRITE: InNewAble=1 and RefillDone=1 for exactly one cycle; InNewIndex/InNewTag/InNewDate valid; then IDLE. Victim way selection stays in stage 1.
- Flush in REQ or FILL sets Cancel. The burst is never aborted: RdReq is held until accepted and all LINE_BEATS beats are drained. Then return to IDLE with no HOLD/WRITE and no RefillDone.
- Flush in HOLD or WRITE is ignored; the line is still written, since the data is valid for the address.
- MissReq outside IDLE is ignored; stage 2 re-raises it after replay.
- Latency, zero-wait memory: MissReq cycle t gives RdReq at t+1. If RdReady at t+1, beats arrive t+2..t+17, HOLD t+18, InNewAble t+19.
- InNewIndex/InNewTag hold the latched values from REQ to IDLE; InNewDate holds the buffer contents.

Optional Feature:
ICACHE_REFILL_TIMEOUT_EN
- Defined: an 8-bit watchdog counts cycles in REQ or FILL without RdReady or RdDataValid progress, and resets on progress.
  - When it reaches TIMEOUT_CYCLES: RefillErr pulses 1 cycle, IcacheStop drops, state goes to IDLE, no write.
- Not defined: no watchdog logic; RefillErr constant 0; controller waits indefinitely.

Test Plan:
- MissPc=32'h1C00_0A44, RdReady immediate, beats 32'h0..32'hF on consecutive cycles -> RdAddr=32'h1C00_0A40, RdLen=15. InNewAble at t+19 with InNewIndex=6'h29, InNewTag=20'h1C000, InNewDate[31:0]=0, InNewDate[511:480]=32'hF. IcacheStop 1 for t+1..t+17.
- RdReady delayed 5 cycles, beats with random 0-3 cycle gaps -> RdReq/RdAddr stable until accept; line assembled in order; single InNewAble pulse.
- IcacheFlash at 3rd beat -> remaining 13 beats drained, no InNewAble/RefillDone, IDLE after 16th beat. Next MissReq accepted.
- MissReq and IcacheFlash same cycle in IDLE -> no RdReq. MissReq during FILL -> ignored, MissPc unchanged.
- Rest=1 asserted mid-FILL, then 4 stray beats -> all outputs 0, state IDLE, beats ignored.
- With ICACHE_REFILL_TIMEOUT_EN: RdReady held 0 for 255 cycles -> RefillErr pulse, IcacheStop 0, no InNewAble. Without the macro: RdReq still high after 300 cycles.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - ICache miss/refill sequencer: one burst read per miss, 512-bit line fill into stage 1
// Optional watchdog: define ICACHE_REFILL_TIMEOUT_EN to abandon a refill that stalls for TIMEOUT_CYCLES cycles.

module icache_refill_ctrl #(
  parameter int LINE_BEATS     = 16,
  parameter int BEAT_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         Clk,
  input  logic                         Rest,
  input  logic                         MissReq,
  input  logic [31:0]                  MissPc,
  input  logic                         IcacheFlash,
  output logic                         IcacheStop,
  output logic                         RdReq,
  output logic [31:0]                  RdAddr,
  output logic [7:0]                   RdLen,
  input  logic                         RdReady,
  input  logic                         RdDataValid,
  input  logic [BEAT_W-1:0]            RdData,
  output logic                         InNewAble,
  output logic [5:0]                   InNewIndex,
  output logic [19:0]                  InNewTag,
  output logic [LINE_BEATS*BEAT_W-1:0] InNewDate,
  output logic                         RefillDone,
  output logic                         RefillErr
);

  localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [7:0] BURST_LEN = 8'(LINE_BEATS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]                   state_q;
  logic [2:0]                   state_d;
  logic [25:0]                  line_pc_q;
  logic [CNT_W-1:0]             beat_cnt_q;
  logic                         cancel_q;
  logic [LINE_BEATS*BEAT_W-1:0] line_q;
  logic                         stop_q;
  logic                         stop_prev_q;
  logic                         miss_take;
  logic                         beat_take;
  logic                         last_beat;
  logic                         busy;
  logic                         timeout_hit;
  logic                         unused_pc_bits;

  // Offset bits within the line never matter: the burst always starts at the line base.
  assign unused_pc_bits = ^MissPc[5:0];

  assign busy      = (state_q == S_REQ) || (state_q == S_FILL);
  assign miss_take = (state_q == S_IDLE) && MissReq && !IcacheFlash;
  assign beat_take = (state_q == S_FILL) && RdDataValid;
  assign last_beat = beat_take && (beat_cnt_q == LAST_BEAT);

`ifdef ICACHE_REFILL_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       progress;
  logic       err_q;

  assign progress    = ((state_q == S_REQ) && RdReady) || beat_take;
  assign timeout_hit = busy && !progress && (wd_q == 8'(TIMEOUT_CYCLES - 1));
  assign RefillErr   = err_q;

  // Watchdog: counts stalled cycles while the memory side owes us something; any progress restarts it.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      wd_q  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (!busy || progress || timeout_hit) begin
        wd_q <= 8'd0;
      end else begin
        wd_q <= wd_q + 8'd1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign RefillErr   = 1'b0;
`endif

  // Next-state selection for the refill sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (miss_take) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (timeout_hit) begin
          state_d = S_IDLE;
        end else if (RdReady) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (timeout_hit) begin
          state_d = S_IDLE;
        end else if (last_beat) begin
          // A flush on the final beat still cancels: the line must not be written.
          state_d = (cancel_q || IcacheFlash) ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus registered stall; stop_prev_q qualifies the stage-1 write.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q     <= S_IDLE;
      stop_q      <= 1'b0;
      stop_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_q      <= (state_d == S_REQ) || (state_d == S_FILL);
      stop_prev_q <= stop_q;
    end
  end

  // Miss address capture; held until the next accepted miss so index/tag stay stable through WRITE.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      line_pc_q <= 26'd0;
    end else if (miss_take) begin
      line_pc_q <= MissPc[31:6];
    end
  end

  // Cancel flag: any flush while the burst is outstanding; cleared whenever we fall back to IDLE.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      cancel_q <= 1'b0;
    end else if (state_d == S_IDLE) begin
      cancel_q <= 1'b0;
    end else if (busy && IcacheFlash) begin
      cancel_q <= 1'b1;
    end
  end

  // Beat counter and line assembly; beats outside FILL never touch the buffer.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      beat_cnt_q <= '0;
      line_q     <= '0;
    end else begin
      if ((state_q == S_REQ) && RdReady) begin
        beat_cnt_q <= '0;
      end else if (beat_take) begin
        line_q[int'(beat_cnt_q) * BEAT_W +: BEAT_W] <= RdData;
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  assign IcacheStop = stop_q;
  assign RdReq      = (state_q == S_REQ);
  assign RdAddr     = {line_pc_q, 6'b0};
  assign RdLen      = RdReq ? BURST_LEN : 8'd0;
  assign InNewAble  = (state_q == S_WRITE) && !stop_prev_q;
  assign RefillDone = InNewAble;
  assign InNewIndex = line_pc_q[5:0];
  assign InNewTag   = line_pc_q[25:6];
  assign InNewDate  = line_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - randomized self-checking bench for icache_refill_ctrl

module tb_icache_refill_ctrl;

  logic         Clk = 1'b0;
  logic         Rest;
  logic         MissReq;
  logic [31:0]  MissPc;
  logic         IcacheFlash;
  logic         IcacheStop;
  logic         RdReq;
  logic [31:0]  RdAddr;
  logic [7:0]   RdLen;
  logic         RdReady;
  logic         RdDataValid;
  logic [31:0]  RdData;
  logic         InNewAble;
  logic [5:0]   InNewIndex;
  logic [19:0]  InNewTag;
  logic [511:0] InNewDate;
  logic         RefillDone;
  logic         RefillErr;

  int n_checks = 0;
  int n_errs   = 0;
  int able_seen = 0;
  int able_exp  = 0;

  logic [31:0] mem_line [16];

  icache_refill_ctrl dut (
    .Clk(Clk), .Rest(Rest), .MissReq(MissReq), .MissPc(MissPc), .IcacheFlash(IcacheFlash),
    .IcacheStop(IcacheStop), .RdReq(RdReq), .RdAddr(RdAddr), .RdLen(RdLen),
    .RdReady(RdReady), .RdDataValid(RdDataValid), .RdData(RdData),
    .InNewAble(InNewAble), .InNewIndex(InNewIndex), .InNewTag(InNewTag),
    .InNewDate(InNewDate), .RefillDone(RefillDone), .RefillErr(RefillErr)
  );

  always #5 Clk = ~Clk;

  // Count every stage-1 write pulse, sampled away from the active edge.
  always @(negedge Clk) begin
    if (InNewAble === 1'b1) able_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [511:0] model_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = mem_line[i];
    return v;
  endfunction

  task automatic idle_inputs();
    MissReq = 0; MissPc = 0; IcacheFlash = 0; RdReady = 0; RdDataValid = 0; RdData = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    Rest = 1;
    step();
    step();
    Rest = 0;
    for (int i = 0; i < 16; i++) mem_line[i] = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {IcacheStop, RdReq, RdAddr, RdLen, InNewAble, InNewIndex, InNewTag, RefillDone, RefillErr}, 0);
    check({tag, "_date"}, InNewDate, 0);
  endtask

  // One full miss: the bench plays the memory side and checks every cycle against the expected sequence.
  task automatic do_refill(input logic [31:0] pc, input int ready_dly, input int max_gap,
                           input int flush_beat, input bit flush_req, input bit flush_hold, input bit seq_data);
    bit          cancel;
    logic [31:0] d;
    int          gap;
    cancel = flush_req || (flush_beat >= 0);
    MissReq = 1; MissPc = pc;
    step();
    MissReq = 0; MissPc = $urandom;
    for (int i = 0; i <= ready_dly; i++) begin
      check("req_rdreq", RdReq, 1);
      check("req_addr", RdAddr, pc & 32'hFFFF_FFC0);
      check("req_len", RdLen, 15);
      check("req_stop", IcacheStop, 1);
      RdReady     = (i == ready_dly);
      RdDataValid = 1'($urandom_range(0, 1));
      RdData      = $urandom;
      IcacheFlash = flush_req && (i == 0);
      MissReq     = 1'($urandom_range(0, 1));
      MissPc      = $urandom;
      step();
    end
    RdReady = 0; IcacheFlash = 0; MissReq = 0; RdDataValid = 0;
    for (int k = 0; k < 16; k++) begin
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        check("gap_stop", IcacheStop, 1);
        check("gap_rdreq", RdReq, 0);
        RdDataValid = 0; MissReq = 1'($urandom_range(0, 1)); MissPc = $urandom;
        step();
      end
      d = seq_data ? 32'(k) : $urandom;
      check("fill_stop", IcacheStop, 1);
      RdDataValid = 1; RdData = d; mem_line[k] = d;
      IcacheFlash = (k == flush_beat);
      MissReq = 1'($urandom_range(0, 1)); MissPc = $urandom;
      step();
    end
    RdDataValid = 0; IcacheFlash = 0; MissReq = 0;
    if (cancel) begin
      check("cancel_stop", IcacheStop, 0);
      check("cancel_rdreq", RdReq, 0);
      check("cancel_able", InNewAble, 0);
      check("cancel_done", RefillDone, 0);
      step();
      check("cancel_able2", InNewAble, 0);
      check("cancel_date", InNewDate, model_line());
    end else begin
      check("hold_stop", IcacheStop, 0);
      check("hold_able", InNewAble, 0);
      IcacheFlash = flush_hold; RdDataValid = 1; RdData = $urandom;
      step();
      IcacheFlash = 0; RdDataValid = 0;
      check("write_able", InNewAble, 1);
      check("write_done", RefillDone, 1);
      check("write_stop", IcacheStop, 0);
      check("write_index", InNewIndex, (pc >> 6) & 32'h3F);
      check("write_tag", InNewTag, pc >> 12);
      check("write_date", InNewDate, model_line());
      able_exp++;
      step();
      check("post_able", InNewAble, 0);
      check("post_done", RefillDone, 0);
    end
  endtask

  initial begin
    logic [511:0] line_v;
    Rest = 1;
    reset_dut();
    check_all_zero("reset");

    // Zero-wait reference refill with a counting pattern.
    do_refill(32'h1C00_0A44, 0, 0, -1, 0, 0, 1);
    line_v = InNewDate;
    check("seq_beat0", line_v[31:0], 32'h0);
    check("seq_beat15", line_v[511:480], 32'hF);
    check("seq_tag_hold", InNewTag, 20'h1C000);
    check("seq_index_hold", InNewIndex, 6'h29);

    // Slow address accept and gappy beats.
    do_refill($urandom, 5, 3, -1, 0, 0, 0);

    // Flush at the third beat, then a fresh miss must still be served.
    do_refill($urandom, 1, 2, 2, 0, 0, 0);
    do_refill($urandom, 0, 1, -1, 0, 1, 0);

    // Miss coincident with flush in IDLE is dropped.
    MissReq = 1; IcacheFlash = 1; MissPc = $urandom;
    step();
    MissReq = 0; IcacheFlash = 0;
    check("flushmiss_rdreq", RdReq, 0);
    check("flushmiss_stop", IcacheStop, 0);
    step();
    check("flushmiss_rdreq2", RdReq, 0);

    // Randomized refills with occasional flushes.
    for (int n = 0; n < 20; n++) begin
      do_refill($urandom, $urandom_range(0, 5), 3,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of FILL, then stray beats.
    MissReq = 1; MissPc = $urandom;
    step();
    MissReq = 0; RdReady = 1;
    step();
    RdReady = 0;
    for (int k = 0; k < 5; k++) begin
      RdDataValid = 1; RdData = $urandom;
      step();
    end
    RdDataValid = 0; Rest = 1;
    step();
    Rest = 0;
    check_all_zero("midrst");
    for (int k = 0; k < 4; k++) begin
      RdDataValid = 1; RdData = $urandom;
      step();
      check("stray_outs", {IcacheStop, RdReq, InNewAble, RefillDone}, 0);
    end
    RdDataValid = 0;
    check("stray_date", InNewDate, 0);
    for (int i = 0; i < 16; i++) mem_line[i] = 32'h0;
    do_refill($urandom, 2, 1, -1, 0, 0, 0);

`ifdef ICACHE_REFILL_TIMEOUT_EN
    MissReq = 1; MissPc = $urandom;
    step();
    MissReq = 0; RdReady = 0;
    for (int i = 0; i < 254; i++) step();
    check("to_before_rdreq", RdReq, 1);
    check("to_before_err", RefillErr, 0);
    step();
    check("to_err", RefillErr, 1);
    check("to_stop", IcacheStop, 0);
    check("to_rdreq", RdReq, 0);
    check("to_able", InNewAble, 0);
    step();
    check("to_err_pulse", RefillErr, 0);
`else
    MissReq = 1; MissPc = $urandom;
    step();
    MissReq = 0; RdReady = 0;
    for (int i = 0; i < 300; i++) step();
    check("wait_rdreq", RdReq, 1);
    check("wait_stop", IcacheStop, 1);
    check("wait_err", RefillErr, 0);
    reset_dut();
`endif

    step();
    check("able_pulse_count", able_seen, able_exp);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
